// File: rtl/pwm_if.sv
// Configuration and pin-drive bundle between the SPI register block and the PWM peripheral.
interface pwm_if;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic [7:0] out_7_0;
    logic [7:0] out_15_8;
    logic       period_start;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle,
        input  out_7_0, out_15_8, period_start
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
               pwm_duty_cycle,
        output out_7_0, out_15_8, period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin PWM driver: shared 255-step period, per-pin off/static/PWM mode, config
// shadowed once per period so an SPI update never tears a cycle.
module pwm_pin (
    input  logic clk,
    input  logic rst,
    input  logic en_out,
    input  logic en_pwm,
    input  logic pwm,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= en_out & (~en_pwm | pwm);
    end
endmodule

module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input logic   clk,
    input logic   rst,
    pwm_if.slave  bus
);
    localparam int             NUM_LANES = 16;
    localparam int             PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PS_MAX    = PW'(CLK_DIV - 1);
    localparam logic [7:0]     STEP_MAX  = 8'd254;

    logic [PW-1:0]          prescaler;
    logic [7:0]             step;
    logic                   primed;
    logic [NUM_LANES-1:0]   en_out_sh;
    logic [NUM_LANES-1:0]   en_pwm_sh;
    logic [7:0]             duty_sh;
    logic [NUM_LANES-1:0]   out;
    logic                   tick, wrap, load, pwm;

    // Counters hold at zero until primed so the first period starts cleanly at step 0.
    assign tick = primed && (prescaler == PS_MAX);
    assign wrap = tick && (step == STEP_MAX);
    assign load = !primed || wrap;
    assign pwm  = (step < duty_sh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed    <= 1'b0;
            prescaler <= '0;
            step      <= '0;
        end else begin
            primed <= 1'b1;
            if (primed) begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
                if (tick) step <= wrap ? 8'd0 : step + 8'd1;
            end
        end
    end

    // On the wrap edge the pins still see the outgoing shadow; new values rule from step 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out_sh <= '0;
            en_pwm_sh <= '0;
            duty_sh   <= '0;
        end else if (load) begin
            en_out_sh <= {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
            en_pwm_sh <= {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
            duty_sh   <= bus.pwm_duty_cycle;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_pin
        pwm_pin u_pin (
            .clk    (clk),
            .rst    (rst),
            .en_out (en_out_sh[g]),
            .en_pwm (en_pwm_sh[g]),
            .pwm    (pwm),
            .q      (out[g])
        );
    end

    assign bus.out_7_0      = out[7:0];
    assign bus.out_15_8     = out[15:8];
    assign bus.period_start = primed && (step == 8'd0) && (prescaler == '0);
endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized bench for pwm_peripheral at two prescaler settings against a
// period/position arithmetic model of the PWM waveform.
module tb_pwm_peripheral;
    localparam int D0 = 3;
    localparam int D1 = 1;

    typedef struct packed {
        logic [15:0] eo;
        logic [15:0] ep;
        logic [7:0]  du;
    } cfg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] en_out = '0;
    logic [15:0] en_pwm = '0;
    logic [7:0]  duty   = '0;

    pwm_if b0();
    pwm_if b1();

    assign b0.en_reg_out_7_0  = en_out[7:0];
    assign b0.en_reg_out_15_8 = en_out[15:8];
    assign b0.en_reg_pwm_7_0  = en_pwm[7:0];
    assign b0.en_reg_pwm_15_8 = en_pwm[15:8];
    assign b0.pwm_duty_cycle  = duty;
    assign b1.en_reg_out_7_0  = en_out[7:0];
    assign b1.en_reg_out_15_8 = en_out[15:8];
    assign b1.en_reg_pwm_7_0  = en_pwm[7:0];
    assign b1.en_reg_pwm_15_8 = en_pwm[15:8];
    assign b1.pwm_duty_cycle  = duty;

    pwm_peripheral #(.CLK_DIV(D0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    pwm_peripheral #(.CLK_DIV(D1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    // Model state: cycles since the prime edge, snapshot of config for the current period.
    bit   m_primed [2];
    int   m_c      [2];
    cfg_t m_sh     [2];
    int   last_ps  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h want 0x%0h", tag, ncyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] drv(input cfg_t s, input int st);
        return s.eo & (~s.ep | ((st < int'(s.du)) ? 16'hFFFF : 16'h0000));
    endfunction

    function automatic logic [15:0] dut_out(input int i);
        return (i == 0) ? {b0.out_15_8, b0.out_7_0} : {b1.out_15_8, b1.out_7_0};
    endfunction

    function automatic logic dut_ps(input int i);
        return (i == 0) ? b0.period_start : b1.period_start;
    endfunction

    // One clock: wait for the falling edge, advance the model by the rising edge that
    // just happened, then compare both DUTs.
    task automatic cycle();
        cfg_t cur;
        @(negedge clk);
        ncyc++;
        cur = '{eo: en_out, ep: en_pwm, du: duty};
        for (int i = 0; i < 2; i++) begin
            int          d, p;
            logic [15:0] eo;
            logic        eps;
            d = (i == 0) ? D0 : D1;
            p = 255 * d;
            if (rst) begin
                m_primed[i] = 1'b0;
                last_ps[i]  = -1;
                eo  = '0;
                eps = 1'b0;
            end else if (!m_primed[i]) begin
                m_primed[i] = 1'b1;
                m_c[i]      = 0;
                m_sh[i]     = cur;
                eo  = '0;
                eps = 1'b1;
            end else begin
                eo = drv(m_sh[i], (m_c[i] % p) / d);
                m_c[i]++;
                if (m_c[i] % p == 0) m_sh[i] = cur;
                eps = (m_c[i] % p == 0);
            end
            chk(i == 0 ? "out_div3" : "out_div1", 32'(dut_out(i)), 32'(eo));
            chk(i == 0 ? "ps_div3" : "ps_div1", 32'(dut_ps(i)), 32'(eps));
            if (dut_ps(i)) begin
                if (last_ps[i] >= 0) chk("ps_gap", 32'(ncyc - last_ps[i]), 32'(p));
                last_ps[i] = ncyc;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] du);
        en_out = eo;
        en_pwm = ep;
        duty   = du;
    endtask

    // Raise reset between edges and confirm the pins clear without waiting for a clock.
    task automatic async_reset(input int hold);
        #2 rst = 1'b1;
        #1;
        chk("arst_out0", 32'(dut_out(0)), 32'h0);
        chk("arst_out1", 32'(dut_out(1)), 32'h0);
        chk("arst_ps",   32'({dut_ps(1), dut_ps(0)}), 32'h0);
        run(hold);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_primed[i] = 1'b0;
            m_c[i]      = 0;
            m_sh[i]     = '0;
            last_ps[i]  = -1;
        end

        run(3);
        set_cfg(16'h0001, 16'h0000, 8'h00);
        rst = 1'b0;
        run(20);

        set_cfg(16'h8001, 16'h8001, 8'h80);
        run(2 * 255 * D0 + 17);

        set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
        run(2 * 255 * D0);
        set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
        run(2 * 255 * D0 + 5);

        set_cfg(16'h00FF, 16'h00FF, 8'h40);
        run(2 * 255 * D0);
        run(100);
        duty = 8'hC0;
        run(2 * 255 * D0);

        set_cfg(16'h0000, 16'hFFFF, 8'hFF);
        run(2 * 255 * D0);

        set_cfg(16'hFFFF, 16'h0000, 8'h10);
        run(2 * 255 * D0);
        async_reset(2);
        run(40);

        for (int r = 0; r < 14; r++) begin
            set_cfg(16'($urandom), 16'($urandom), 8'($urandom));
            run(int'($urandom_range(50, 1200)));
            if ($urandom_range(0, 4) == 0) begin
                async_reset(int'($urandom_range(1, 3)));
                run(int'($urandom_range(5, 60)));
            end
        end
        run(255 * D0 + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
